omp_bram_rd_arbiter: RTL and testbench
======================================

OMP_BRAM_RD_ARBITER -- requirements
Module: omp_bram_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning BRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 96, meaning BRAM read-data width.
REQ-003 SHALL have parameter RD_LAT, default 1, legal 1..4, meaning BRAM cycles from registered enable to valid read data.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-006 SHALL have port req_valid, input, 3, meaning per-requester read request (bit0 core AB, bit1 block C, bit2 host readout).
REQ-007 SHALL have port req_lock, input, 3, meaning the requester wants to keep ownership after this transfer.
REQ-008 SHALL have port req_addr, input, 3*ADDR_W, meaning requester i address at [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_ready, output, 3, meaning one-hot grant (combinational); a transfer is accepted when req_valid[i] & req_ready[i].
REQ-010 SHALL have port bram_en, output, 1, meaning registered BRAM read enable.
REQ-011 SHALL have port bram_addr, output, ADDR_W, meaning registered BRAM read address.
REQ-012 SHALL have port bram_rdata, input, DATA_W, meaning BRAM read data.
REQ-013 SHALL have port rsp_valid, output, 3, meaning one-hot return strobe for the requester owning bram_rdata this cycle.
REQ-014 SHALL have port rsp_data, output, DATA_W, meaning bram_rdata passed through unregistered.
REQ-015 SHALL have port owner, output, 2, meaning index of the locked owner (3 = none).
REQ-016 SHALL have port busy, output, 1, meaning any read in flight or lock held.

Function
REQ-017 SHALL assert at most one req_ready bit per cycle, and only for a requester with req_valid high.
REQ-018 SHALL implement FSM states S_OPEN (any requester eligible) and S_LOCKED (only owner eligible).
REQ-019 SHALL move S_OPEN->S_LOCKED, owner<=i, on an accepted transfer from i with req_lock[i]=1.
REQ-020 SHALL move S_LOCKED->S_OPEN, owner<=3, on an accepted owner transfer with req_lock[owner]=0; an owner transfer with lock=1 stays locked.
REQ-021 SHALL, in S_LOCKED, hold req_ready=0 for non-owners regardless of their req_valid, and keep the lock while the owner idles.
REQ-022 SHALL, for a transfer accepted in cycle t, drive bram_en=1 and bram_addr=req_addr of the winner in cycle t+1, else bram_en=0 with bram_addr held.
REQ-023 SHALL carry the winner index through an RD_LAT-deep tag pipeline, asserting rsp_valid[i] in cycle t+1+RD_LAT, coincident with bram_rdata.
REQ-024 SHALL sustain one accepted transfer per cycle (full throughput) with responses in acceptance order.
REQ-025 SHALL assert busy when state=S_LOCKED, bram_en=1, or any tag-pipeline entry is valid.
REQ-026 SHALL ignore req_lock on non-accepted cycles and req_addr of non-granted requesters.

Reset
REQ-027 SHALL, on rst high at a clock edge, set state=S_OPEN, owner=3, bram_en=0, bram_addr=0, all tag-pipeline entries invalid, RR pointer=2.
REQ-028 SHALL hold req_ready=0 and rsp_valid=0 during any cycle rst is high; reads in flight at reset produce no rsp_valid afterwards.

Configuration
REQ-029 SHALL, with macro OMP_ARB_ROUND_ROBIN_EN defined, arbitrate S_OPEN round-robin: search starts at (last accepted index + 1) mod 3, pointer updated on every accepted transfer.
REQ-030 SHALL, without OMP_ARB_ROUND_ROBIN_EN, arbitrate S_OPEN fixed-priority: bit0 > bit1 > bit2; no pointer register exists.

Verification
REQ-031 SHALL cover: single req_valid=3'b010, addr 7'd5, RD_LAT=1 -> req_ready=3'b010 cycle t, bram_en=1 addr 5 at t+1, rsp_valid=3'b010 at t+2.
REQ-032 SHALL cover: req_valid=3'b111 held 6 cycles, no lock -> RR build grants 0,1,2,0,1,2; fixed build grants 0 six times.
REQ-033 SHALL cover: requester 2 accepted with lock=1, then requesters 0,1 valid 4 cycles while 2 idle -> req_ready=0, owner=2; requester 2 transfer with lock=0 -> owner=3, next cycle requester 0 granted.
REQ-034 SHALL cover: back-to-back accepts addr 10,11,12 from requesters 0,1,0 with RD_LAT=3 -> bram_addr 10,11,12 at t+1..t+3, rsp_valid 001,010,001 at t+4..t+6.
REQ-035 SHALL cover: rst asserted one cycle after an accept with RD_LAT=2 -> no rsp_valid ever for that read, busy=0 and owner=3 after reset.

Source files
------------

// File: rtl/omp_bram_rd_arbiter.sv
// ---------------------------------------------------------------------------
// omp_bram_rd_arbiter
//
// Shares one BRAM read port between three requesters:
//   bit0 = core AB, bit1 = block C, bit2 = host readout.
// A requester may take a lock with its transfer. It then keeps the port
// until it makes a transfer with the lock released. The enable and address
// are registered toward the BRAM. A tag pipeline RD_LAT stages deep routes
// each read-data beat back to the requester that issued it.
//
// Optional build macro:
//   OMP_ARB_ROUND_ROBIN_EN - when defined, the open state uses round-robin
//                            arbitration. When undefined, it uses fixed
//                            priority (bit0 > bit1 > bit2).
//
// Parameters:
//   ADDR_W  BRAM word-address width
//   DATA_W  BRAM read-data width
//   RD_LAT  cycles from registered enable to valid read data (1..4)
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   req_valid   per-requester read request
//   req_lock    keep ownership after this transfer
//   req_addr    requester i address at [i*ADDR_W +: ADDR_W]
//   req_ready   one-hot combinational grant
//   bram_en     registered BRAM read enable
//   bram_addr   registered BRAM read address (held when idle)
//   bram_rdata  BRAM read data
//   rsp_valid   one-hot strobe for the owner of bram_rdata this cycle
//   rsp_data    bram_rdata passed through
//   owner       locked owner index, 3 = none
//   busy        read in flight or lock held
// ---------------------------------------------------------------------------
module omp_bram_rd_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 96,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req_valid,
    input  logic [2:0]            req_lock,
    input  logic [3*ADDR_W-1:0]   req_addr,
    output logic [2:0]            req_ready,
    output logic                  bram_en,
    output logic [ADDR_W-1:0]     bram_addr,
    input  logic [DATA_W-1:0]     bram_rdata,
    output logic [2:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [1:0]            owner,
    output logic                  busy
);

    localparam logic [0:0] S_OPEN   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    localparam logic [1:0] NO_OWNER = 2'd3;

    logic [0:0]        state;
    logic [1:0]        owner_q;
    logic [2:0]        grant;
    logic              accept;
    logic              lock_win;
    logic [1:0]        win_idx;
    logic [ADDR_W-1:0] win_addr;

    // Stage 0 lines up with bram_en. Stage RD_LAT lines up with bram_rdata.
    logic [RD_LAT:0]        vld_pipe;
    logic [RD_LAT:0][1:0]   idx_pipe;

`ifdef OMP_ARB_ROUND_ROBIN_EN
    // Holds the last accepted index. The search begins one past it.
    logic [1:0] rr_ptr;
`endif

    // ---------------- grant ----------------
    always_comb begin
        grant = 3'b000;
        if (!rst) begin
            if (state == S_LOCKED) begin
                // Only the owner is eligible. Other requesters wait,
                // including while the owner is idle.
                case (owner_q)
                    2'd0:    grant[0] = req_valid[0];
                    2'd1:    grant[1] = req_valid[1];
                    2'd2:    grant[2] = req_valid[2];
                    default: grant    = 3'b000;
                endcase
            end else begin
`ifdef OMP_ARB_ROUND_ROBIN_EN
                case (rr_ptr)
                    2'd0: begin      // search order 1,2,0
                        if      (req_valid[1]) grant = 3'b010;
                        else if (req_valid[2]) grant = 3'b100;
                        else if (req_valid[0]) grant = 3'b001;
                    end
                    2'd1: begin      // search order 2,0,1
                        if      (req_valid[2]) grant = 3'b100;
                        else if (req_valid[0]) grant = 3'b001;
                        else if (req_valid[1]) grant = 3'b010;
                    end
                    default: begin   // search order 0,1,2
                        if      (req_valid[0]) grant = 3'b001;
                        else if (req_valid[1]) grant = 3'b010;
                        else if (req_valid[2]) grant = 3'b100;
                    end
                endcase
`else
                if      (req_valid[0]) grant = 3'b001;
                else if (req_valid[1]) grant = 3'b010;
                else if (req_valid[2]) grant = 3'b100;
`endif
            end
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    // Lock bits of requesters that were not granted are ignored.
    assign lock_win  = |(req_lock & grant);

    always_comb begin
        win_idx  = 2'd0;
        win_addr = req_addr[0 +: ADDR_W];
        if (grant[1]) begin
            win_idx  = 2'd1;
            win_addr = req_addr[ADDR_W +: ADDR_W];
        end else if (grant[2]) begin
            win_idx  = 2'd2;
            win_addr = req_addr[2*ADDR_W +: ADDR_W];
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_OPEN;
            owner_q   <= NO_OWNER;
            bram_en   <= 1'b0;
            bram_addr <= '0;
            vld_pipe  <= '0;
            idx_pipe  <= '0;
        end else begin
            bram_en <= accept;
            if (accept) bram_addr <= win_addr;

            vld_pipe <= {vld_pipe[RD_LAT-1:0], accept};
            idx_pipe <= {idx_pipe[RD_LAT-1:0], win_idx};

            case (state)
                S_OPEN: begin
                    if (accept && lock_win) begin
                        state   <= S_LOCKED;
                        owner_q <= win_idx;
                    end
                end
                default: begin
                    // Any accept here comes from the owner.
                    if (accept && !lock_win) begin
                        state   <= S_OPEN;
                        owner_q <= NO_OWNER;
                    end
                end
            endcase
        end
    end

`ifdef OMP_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst)         rr_ptr <= 2'd2;
        else if (accept) rr_ptr <= win_idx;
    end
`endif

    // ---------------- response ----------------
    always_comb begin
        rsp_valid = 3'b000;
        if (!rst && vld_pipe[RD_LAT]) begin
            case (idx_pipe[RD_LAT])
                2'd0:    rsp_valid = 3'b001;
                2'd1:    rsp_valid = 3'b010;
                2'd2:    rsp_valid = 3'b100;
                default: rsp_valid = 3'b000;
            endcase
        end
    end

    assign rsp_data = bram_rdata;
    assign owner    = owner_q;
    // vld_pipe[0] is set in the same cycles as bram_en.
    assign busy     = (state == S_LOCKED) || bram_en || (|vld_pipe);

endmodule

// File: tb/tb_omp_bram_rd_arbiter.sv
// Bench for omp_bram_rd_arbiter. Three instances run with RD_LAT = 1, 2 and 3.
// All three get the same stimulus. Grants and owner come from a
// hand-written table. BRAM enable/address and responses are scoreboarded
// per instance using its own latency.
module tb_omp_bram_rd_arbiter;
    localparam int AW = 7;
    localparam int DW = 96;
    localparam int NV = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [2:0]        req_valid, req_lock;
    logic [3*AW-1:0]   req_addr;
    logic [DW-1:0]     bram_rdata;

    logic [2:0]    rdy   [3];
    logic          en    [3];
    logic [AW-1:0] baddr [3];
    logic [2:0]    rsp   [3];
    logic [DW-1:0] rdo   [3];
    logic [1:0]    own   [3];
    logic          bsy   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        omp_bram_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(g + 1)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid), .req_lock(req_lock), .req_addr(req_addr),
            .req_ready(rdy[g]), .bram_en(en[g]), .bram_addr(baddr[g]),
            .bram_rdata(bram_rdata), .rsp_valid(rsp[g]), .rsp_data(rdo[g]),
            .owner(own[g]), .busy(bsy[g])
        );
    end

    typedef struct {
        logic          rst;
        logic [2:0]    valid;
        logic [2:0]    lock;
        logic [AW-1:0] a0, a1, a2;
        logic [2:0]    exp_ready;
        logic [1:0]    exp_owner;
    } vec_t;

    typedef struct {
        int         d;
        int         due;
        logic [2:0] oh;
    } rsp_t;

    vec_t tab [NV];
    rsp_t q[$];

    int            checks = 0;
    int            errors = 0;
    int            cyc;
    logic          exp_en;
    logic [AW-1:0] exp_addr;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic r, input logic [2:0] v, input logic [2:0] l,
                        input int a0, input int a1, input int a2,
                        input logic [2:0] er, input logic [1:0] eo);
        tab[i].rst       = r;
        tab[i].valid     = v;
        tab[i].lock      = l;
        tab[i].a0        = AW'(a0);
        tab[i].a1        = AW'(a1);
        tab[i].a2        = AW'(a2);
        tab[i].exp_ready = er;
        tab[i].exp_owner = eo;
    endtask

    initial begin
        // all requesters valid for 6 cycles, no lock
`ifdef OMP_ARB_ROUND_ROBIN_EN
        setv(0, 0, 3'b111, 3'b000, 20, 21, 22, 3'b001, 3);
        setv(1, 0, 3'b111, 3'b000, 23, 24, 25, 3'b010, 3);
        setv(2, 0, 3'b111, 3'b000, 26, 27, 28, 3'b100, 3);
        setv(3, 0, 3'b111, 3'b000, 20, 21, 22, 3'b001, 3);
        setv(4, 0, 3'b111, 3'b000, 23, 24, 25, 3'b010, 3);
        setv(5, 0, 3'b111, 3'b000, 26, 27, 28, 3'b100, 3);
`else
        setv(0, 0, 3'b111, 3'b000, 20, 21, 22, 3'b001, 3);
        setv(1, 0, 3'b111, 3'b000, 23, 24, 25, 3'b001, 3);
        setv(2, 0, 3'b111, 3'b000, 26, 27, 28, 3'b001, 3);
        setv(3, 0, 3'b111, 3'b000, 29, 21, 22, 3'b001, 3);
        setv(4, 0, 3'b111, 3'b000, 50, 24, 25, 3'b001, 3);
        setv(5, 0, 3'b111, 3'b000, 51, 27, 28, 3'b001, 3);
`endif
        // single request from block C, addr 5
        setv(6,  0, 3'b010, 3'b000,  1,  5,  2, 3'b010, 3);
        setv(7,  0, 3'b000, 3'b000,  0,  0,  0, 3'b000, 3);
        // lock with no accept is ignored
        setv(8,  0, 3'b000, 3'b111,  0,  0,  0, 3'b000, 3);
        setv(9,  0, 3'b000, 3'b000,  0,  0,  0, 3'b000, 3);
        // back-to-back 10,11,12 from 0,1,0
        setv(10, 0, 3'b001, 3'b000, 10, 99, 98, 3'b001, 3);
        setv(11, 0, 3'b010, 3'b000, 97, 11, 96, 3'b010, 3);
        setv(12, 0, 3'b001, 3'b000, 12, 95, 94, 3'b001, 3);
        setv(13, 0, 3'b000, 3'b000,  0,  0,  0, 3'b000, 3);
        // host takes the lock, others starve while it idles
        setv(14, 0, 3'b100, 3'b100, 31, 32, 30, 3'b100, 3);
        setv(15, 0, 3'b011, 3'b011, 40, 41, 42, 3'b000, 2);
        setv(16, 0, 3'b011, 3'b011, 40, 41, 42, 3'b000, 2);
        setv(17, 0, 3'b011, 3'b011, 40, 41, 42, 3'b000, 2);
        setv(18, 0, 3'b011, 3'b011, 40, 41, 42, 3'b000, 2);
        setv(19, 0, 3'b111, 3'b100, 43, 45, 33, 3'b100, 2);
        setv(20, 0, 3'b011, 3'b000, 40, 41, 42, 3'b000, 2);
        setv(21, 0, 3'b111, 3'b000, 46, 47, 34, 3'b100, 2);
        setv(22, 0, 3'b011, 3'b000, 35, 36, 37, 3'b001, 3);
        setv(23, 0, 3'b000, 3'b000,  0,  0,  0, 3'b000, 3);
        // reset one cycle after a locking accept
        setv(24, 0, 3'b001, 3'b001, 44, 48, 49, 3'b001, 3);
        setv(25, 1, 3'b111, 3'b111, 52, 53, 54, 3'b000, 0);
        for (int i = 26; i < NV; i++) setv(i, 0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3);

        // reset state
        rst        = 1'b1;
        req_valid  = 3'b111;
        req_lock   = 3'b000;
        req_addr   = '1;
        bram_rdata = '0;
        @(posedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_ready lat%0d", d + 1), DW'(rdy[d]), DW'(3'b000));
            chk($sformatf("reset_rsp lat%0d", d + 1), DW'(rsp[d]), DW'(3'b000));
            chk($sformatf("reset_owner lat%0d", d + 1), DW'(own[d]), DW'(2'd3));
            chk($sformatf("reset_en lat%0d", d + 1), DW'(en[d]), DW'(1'b0));
            chk($sformatf("reset_addr lat%0d", d + 1), DW'(baddr[d]), DW'(0));
            chk($sformatf("reset_busy lat%0d", d + 1), DW'(bsy[d]), DW'(1'b0));
        end
        exp_en   = 1'b0;
        exp_addr = '0;

        for (cyc = 0; cyc < NV; cyc++) begin
            rst        = tab[cyc].rst;
            req_valid  = tab[cyc].valid;
            req_lock   = tab[cyc].lock;
            req_addr   = {tab[cyc].a2, tab[cyc].a1, tab[cyc].a0};
            bram_rdata = {$urandom, $urandom, $urandom};
            #1;
            for (int d = 0; d < 3; d++) begin
                logic [2:0] exp_rsp;
                logic       pend;
                int         hit;
                exp_rsp = 3'b000;
                pend    = 1'b0;
                hit     = -1;
                foreach (q[k]) begin
                    if (q[k].d == d) begin
                        pend = 1'b1;
                        if (q[k].due == cyc) hit = k;
                    end
                end
                if (hit >= 0 && !tab[cyc].rst) begin
                    exp_rsp = q[hit].oh;
                    q.delete(hit);
                end
                chk($sformatf("ready v%0d lat%0d", cyc, d + 1), DW'(rdy[d]), DW'(tab[cyc].exp_ready));
                chk($sformatf("owner v%0d lat%0d", cyc, d + 1), DW'(own[d]), DW'(tab[cyc].exp_owner));
                chk($sformatf("bram_en v%0d lat%0d", cyc, d + 1), DW'(en[d]), DW'(exp_en));
                chk($sformatf("bram_addr v%0d lat%0d", cyc, d + 1), DW'(baddr[d]), DW'(exp_addr));
                chk($sformatf("rsp_valid v%0d lat%0d", cyc, d + 1), DW'(rsp[d]), DW'(exp_rsp));
                chk($sformatf("rsp_data v%0d lat%0d", cyc, d + 1), rdo[d], bram_rdata);
                if (!tab[cyc].rst)
                    chk($sformatf("busy v%0d lat%0d", cyc, d + 1), DW'(bsy[d]),
                        DW'((tab[cyc].exp_owner != 2'd3) || pend));
            end
            @(posedge clk);
            if (tab[cyc].rst) begin
                q.delete();
                exp_en   = 1'b0;
                exp_addr = '0;
            end else begin
                exp_en = |tab[cyc].exp_ready;
                if (tab[cyc].exp_ready[0]) exp_addr = tab[cyc].a0;
                if (tab[cyc].exp_ready[1]) exp_addr = tab[cyc].a1;
                if (tab[cyc].exp_ready[2]) exp_addr = tab[cyc].a2;
                if (exp_en)
                    for (int d = 0; d < 3; d++) begin
                        rsp_t e;
                        e.d   = d;
                        e.due = cyc + 2 + d;
                        e.oh  = tab[cyc].exp_ready;
                        q.push_back(e);
                    end
            end
            @(negedge clk);
        end

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
